// File: rtl/ha_serial_add_sched_if.sv
// Request/response bundle for the shared half-adder serial adder.
// The slave side is the adder itself; the master side drives requests and consumes results.
interface ha_serial_add_sched_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic [W-1:0] resp_sum;
    logic         resp_cout;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_sum, resp_cout, busy
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_sum, resp_cout, busy
    );
endinterface

// File: rtl/ha_serial_add_sched.sv
// Bit-serial adder that time-shares one half adder between two round-robin requesters.
// Each bit takes two passes (A+B, then partial sum + carry); the result returns on a valid/ready port.
module ha_serial_add_sched #(
    parameter int W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    ha_serial_add_sched_if.slave     bus
);
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, P1, P2, DONE} state_t;

    state_t        state_reg;
    logic [IW-1:0] idx_reg;
    logic          carry_reg;
    logic          s1_reg;
    logic          c1_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          last_served_reg;
    logic          resp_valid_reg;
    logic          resp_id_reg;
    logic          resp_cout_reg;
    logic [W-1:0]  resp_sum_reg;
    logic          busy_reg;

    logic [W-1:0]  bit_sel;
    logic          a_bit;
    logic          b_bit;
    logic          ha_x;
    logic          ha_y;
    logic          ha_s;
    logic          ha_c;
    logic          grant0;
    logic          grant1;
    logic          favoured;

    // One-hot select of the current bit; avoids a variable part-select when W==1.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_sel
            assign bit_sel[gi] = (idx_reg == IW'(gi));
        end
    endgenerate

    assign a_bit = |(a_reg & bit_sel);
    assign b_bit = |(b_reg & bit_sel);

    // The single shared half adder; its inputs are steered by the pass.
    always_comb begin
        ha_x = 1'b0;
        ha_y = 1'b0;
        if (state_reg == P1) begin
            ha_x = a_bit;
            ha_y = b_bit;
        end else if (state_reg == P2) begin
            ha_x = s1_reg;
            ha_y = carry_reg;
        end
        ha_s = ha_x ^ ha_y;
        ha_c = ha_x & ha_y;
    end

    assign favoured = ~last_served_reg;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE && !rst) begin
            if (favoured == 1'b0) begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid & ~bus.req0_valid;
            end else begin
                grant1 = bus.req1_valid;
                grant0 = bus.req0_valid & ~bus.req1_valid;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= '0;
            carry_reg       <= 1'b0;
            s1_reg          <= 1'b0;
            c1_reg          <= 1'b0;
            a_reg           <= '0;
            b_reg           <= '0;
            last_served_reg <= 1'b1;
            resp_valid_reg  <= 1'b0;
            resp_id_reg     <= 1'b0;
            resp_cout_reg   <= 1'b0;
            resp_sum_reg    <= '0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg         <= grant1 ? bus.req1_a : bus.req0_a;
                        b_reg         <= grant1 ? bus.req1_b : bus.req0_b;
                        resp_id_reg   <= grant1;
                        resp_sum_reg  <= '0;
                        resp_cout_reg <= 1'b0;
                        idx_reg       <= '0;
                        carry_reg     <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= P1;
                    end
                end
                P1: begin
                    s1_reg    <= ha_s;
                    c1_reg    <= ha_c;
                    state_reg <= P2;
                end
                P2: begin
                    resp_sum_reg <= (resp_sum_reg & ~bit_sel) | (ha_s ? bit_sel : '0);
                    carry_reg    <= c1_reg | ha_c;
                    if (idx_reg == LAST_IDX) begin
                        resp_cout_reg  <= c1_reg | ha_c;
                        resp_valid_reg <= 1'b1;
                        state_reg      <= DONE;
                    end else begin
                        idx_reg   <= idx_reg + IW'(1);
                        state_reg <= P1;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        last_served_reg <= resp_id_reg;
                        resp_valid_reg  <= 1'b0;
                        busy_reg        <= 1'b0;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.resp_valid = resp_valid_reg;
    assign bus.resp_id    = resp_id_reg;
    assign bus.resp_sum   = resp_sum_reg;
    assign bus.resp_cout  = resp_cout_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_ha_serial_add_sched.sv
// Bench for the shared half-adder serial adder: table vectors, hand-written corner
// sequences (arbitration from reset, back-pressure, mid-op reset, W=1) and random traffic.
module tb_ha_serial_add_sched;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ha_serial_add_sched_if #(.W(8)) bus8 ();
    ha_serial_add_sched_if #(.W(1)) bus1 ();

    ha_serial_add_sched #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    ha_serial_add_sched #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        bit         cout;
        int         hold;
    } vec_t;

    vec_t tbl [6];
    int   total = 0;
    int   bad   = 0;
    bit   last_ref = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rdy8(input bit id);
        return id ? bus8.req1_ready : bus8.req0_ready;
    endfunction

    task automatic set_req(input bit id, input logic v, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            bus8.req1_valid = v; bus8.req1_a = a; bus8.req1_b = b;
        end else begin
            bus8.req0_valid = v; bus8.req0_a = a; bus8.req0_b = b;
        end
    endtask

    // Waits (bounded) for ready, then takes the accept edge.
    task automatic wait_accept(input bit id);
        int n = 0;
        #1;
        while (rdy8(id) !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk("accept_wait", 32'(n < 30), 32'd1);
        step();
    endtask

    task automatic wait_done(output int lat, output bit rdy_seen);
        lat = 0;
        rdy_seen = 1'b0;
        while (bus8.resp_valid !== 1'b1 && lat < 100) begin
            if (bus8.req0_ready !== 1'b0 || bus8.req1_ready !== 1'b0) rdy_seen = 1'b1;
            step();
            lat++;
        end
    endtask

    task automatic finish_resp(input int hold, input bit exp_id, input logic [7:0] exp_sum,
                               input bit exp_cout, input bit poke_other);
        for (int h = 0; h < hold; h++) begin
            if (poke_other) set_req(~exp_id, 1'b1, 8'($urandom), 8'($urandom));
            step();
            chk("hold_stable",
                {21'd0, bus8.resp_valid, bus8.req0_ready, bus8.req1_ready, bus8.resp_id, bus8.resp_cout, bus8.resp_sum},
                {21'd0, 1'b1, 1'b0, 1'b0, exp_id, exp_cout, exp_sum});
        end
        bus8.resp_ready = 1'b1;
        step();
        chk("idle_after_hs", {bus8.resp_valid, bus8.busy}, 2'b00);
        bus8.resp_ready = 1'b0;
        if (poke_other) set_req(~exp_id, 1'b0, 8'h00, 8'h00);
        last_ref = exp_id;
    endtask

    task automatic serve(input bit id, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_sum, input bit exp_cout, input int hold);
        int lat;
        bit seen;
        set_req(id, 1'b1, a, b);
        wait_accept(id);
        set_req(id, 1'b0, 8'($urandom), 8'($urandom));
        wait_done(lat, seen);
        chk("latency", lat, 16);
        chk("sum", bus8.resp_sum, exp_sum);
        chk("cout", bus8.resp_cout, exp_cout);
        chk("id", bus8.resp_id, id);
        chk("ready_during_op", seen, 0);
        finish_resp(hold, id, exp_sum, exp_cout, 1'b1);
    endtask

    initial begin
        int         lat;
        bit         seen;
        logic [1:0] v;
        logic [7:0] a0, b0, a1, b1;
        logic [8:0] full;
        bit         fav, exp_id;

        tbl[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 0};
        tbl[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 0};
        tbl[2] = '{1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 5};
        tbl[3] = '{1'b1, 8'h12, 8'h34, 8'h46, 1'b0, 2};
        tbl[4] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 1'b1, 0};
        tbl[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1};

        bus8.req0_valid = 0; bus8.req0_a = 0; bus8.req0_b = 0;
        bus8.req1_valid = 0; bus8.req1_a = 0; bus8.req1_b = 0;
        bus8.resp_ready = 0;
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0;
        bus1.resp_ready = 0;

        // Reset with both requesters already valid (T3 setup).
        #2 rst = 1'b1;
        set_req(0, 1'b1, 8'd3, 8'd4);
        set_req(1, 1'b1, 8'd10, 8'd20);
        step(); step();
        chk("rst_outputs", {bus8.resp_valid, bus8.resp_id, bus8.resp_cout, bus8.busy, bus8.resp_sum}, 12'h000);
        chk("rst_readies", {bus8.req0_ready, bus8.req1_ready}, 2'b00);
        chk("rst_w1", {bus1.resp_valid, bus1.resp_sum, bus1.resp_cout, bus1.busy}, 4'h0);
        rst = 1'b0;
        last_ref = 1'b1;
        #1;
        chk("t3_arb", {bus8.req0_ready, bus8.req1_ready}, 2'b10);
        step();
        set_req(0, 1'b0, 8'hEE, 8'hEE);
        wait_done(lat, seen);
        chk("t3_lat0", lat, 16);
        chk("t3_sum0", {bus8.resp_id, bus8.resp_cout, bus8.resp_sum}, {1'b0, 1'b0, 8'd7});
        chk("t3_r1_blocked", seen, 0);
        finish_resp(0, 1'b0, 8'd7, 1'b0, 1'b0);
        chk("t3_r1_now", {bus8.req0_ready, bus8.req1_ready}, 2'b01);
        step();
        set_req(1, 1'b0, 8'h00, 8'h00);
        wait_done(lat, seen);
        chk("t3_lat1", lat, 16);
        chk("t3_sum1", {bus8.resp_id, bus8.resp_cout, bus8.resp_sum}, {1'b1, 1'b0, 8'd30});
        finish_resp(0, 1'b1, 8'd30, 1'b0, 1'b0);

        // Table vectors (T1, T2, T4 back-pressure and more).
        for (int k = 0; k < 6; k++)
            serve(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].sum, tbl[k].cout, tbl[k].hold);

        // Random traffic against a round-robin + plain-arithmetic model.
        for (int k = 0; k < 30; k++) begin
            v  = 2'($urandom_range(1, 3));
            a0 = 8'($urandom); b0 = 8'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom);
            set_req(0, v[0], a0, b0);
            set_req(1, v[1], a1, b1);
            #1;
            fav = ~last_ref;
            exp_id = v[fav] ? fav : ~fav;
            chk("rnd_grant", {bus8.req0_ready, bus8.req1_ready}, {exp_id == 1'b0, exp_id == 1'b1});
            step();
            set_req(0, 1'b0, 8'($urandom), 8'($urandom));
            set_req(1, 1'b0, 8'($urandom), 8'($urandom));
            full = exp_id ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
            wait_done(lat, seen);
            chk("rnd_lat", lat, 16);
            chk("rnd_result", {bus8.resp_id, bus8.resp_cout, bus8.resp_sum}, {exp_id, full});
            finish_resp($urandom_range(0, 3), exp_id, full[7:0], full[8], 1'b1);
        end

        // T5: reset during P2 of bit 3, request still pending afterwards.
        set_req(0, 1'b1, 8'hC7, 8'h5E);
        wait_accept(0);
        for (int k = 0; k < 7; k++) step();
        chk("t5_busy", bus8.busy, 1'b1);
        rst = 1'b1;
        set_req(1, 1'b1, 8'h11, 8'h22);
        #1;
        chk("t5_rst_out", {bus8.resp_valid, bus8.resp_id, bus8.resp_cout, bus8.busy, bus8.resp_sum}, 12'h000);
        chk("t5_rst_rdy", {bus8.req0_ready, bus8.req1_ready}, 2'b00);
        step(); step();
        chk("t5_no_resp", bus8.resp_valid, 1'b0);
        rst = 1'b0;
        last_ref = 1'b1;
        #1;
        chk("t5_rearb", {bus8.req0_ready, bus8.req1_ready}, 2'b10);
        step();
        set_req(0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 8'h00, 8'h00);
        wait_done(lat, seen);
        chk("t5_lat", lat, 16);
        chk("t5_result", {bus8.resp_id, bus8.resp_cout, bus8.resp_sum}, {1'b0, 1'b1, 8'h25});
        finish_resp(0, 1'b0, 8'h25, 1'b1, 1'b0);

        // T6: W=1 instance.
        bus1.req0_valid = 1'b1; bus1.req0_a = 1'b1; bus1.req0_b = 1'b1;
        #1;
        chk("t6_ready", bus1.req0_ready, 1'b1);
        step();
        bus1.req0_valid = 1'b0; bus1.req0_a = 1'b0; bus1.req0_b = 1'b0;
        lat = 0;
        while (bus1.resp_valid !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk("t6_lat", lat, 2);
        chk("t6_result", {bus1.resp_id, bus1.resp_cout, bus1.resp_sum}, 3'b010);
        bus1.resp_ready = 1'b1;
        step();
        chk("t6_idle", {bus1.resp_valid, bus1.busy}, 2'b00);
        bus1.resp_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
